// File: rtl/tx_hold_fifo.sv
// UART transmit holding register / FIFO: a single-entry holding register or a
// DEPTH-entry circular FIFO feeding the transmit shift register.
module tx_hold_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
) (
   input  logic                    pclk,
   input  logic                    presetn,
   input  logic                    wr_en,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic                    fifo_en,
   input  logic                    fifo_clr,
   input  logic                    tsr_load,
   input  logic                    not_op,
   output logic [DATA_WIDTH-1:0]   tsr_data,
   output logic                    thre,
   output logic                    temt,
   output logic                    full,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    ovr_err,
   output logic                    thre_int
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CAP_FIFO = (AW+1)'(DEPTH);
   localparam logic [AW:0] CAP_HOLD = (AW+1)'(1);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [AW:0]           r_count;
   logic                  r_fifo_en_q;
   logic                  r_ovr_err;
   logic                  r_thre_int;

   logic [AW:0]           w_cap;
   logic [AW:0]           w_count_nxt;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_flush;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_drop;

   // Capacity follows the sampled mode; in the one cycle where the input
   // differs from it the implicit flush wins, so count never exceeds capacity.
   always_comb begin
      w_cap       = r_fifo_en_q ? CAP_FIFO : CAP_HOLD;
      w_full      = (r_count == w_cap);
      w_empty     = (r_count == '0);
      w_flush     = fifo_clr | (fifo_en != r_fifo_en_q);
      w_pop       = tsr_load & ~w_empty & ~w_flush;
      w_push      = wr_en & (~w_full | w_pop) & ~w_flush;
      w_drop      = wr_en & w_full & ~w_pop & ~w_flush;
      w_count_nxt = r_count;
      if (w_flush) begin
         w_count_nxt = '0;
      end else begin
         w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end

   always_ff @(posedge pclk) begin
      if (!presetn) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_fifo_en_q <= 1'b0;
         r_ovr_err   <= 1'b0;
         r_thre_int  <= 1'b0;
      end else begin
         r_fifo_en_q <= fifo_en;
         r_count     <= w_count_nxt;
         r_ovr_err   <= w_drop;
         r_thre_int  <= ~w_empty & (w_count_nxt == '0);
         if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         end
      end
   end

   // Storage has no reset; pointers and count alone define validity.
   always_ff @(posedge pclk) begin
      if (presetn && w_push) begin
         r_mem[r_wr_ptr] <= wdata;
      end
   end

   assign tsr_data = r_mem[r_rd_ptr];
   assign thre     = w_empty;
   assign temt     = w_empty & not_op;
   assign full     = w_full;
   assign count    = r_count;
   assign ovr_err  = r_ovr_err;
   assign thre_int = r_thre_int;

endmodule

// File: doc/tx_hold_fifo.md
TX_HOLD_FIFO -- requirements
Module: tx_hold_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, character width.
REQ-002 SHALL have parameter DEPTH, default 16, FIFO-mode capacity; power of two, >= 2.
REQ-003 SHALL have port pclk, input, 1, the only clock; all state updates on its rising edge.
REQ-004 SHALL have port presetn, input, 1, synchronous active-low reset.
REQ-005 SHALL have port wr_en, input, 1, single-cycle pulse: write wdata to holding register/FIFO.
REQ-006 SHALL have port wdata, input, DATA_WIDTH, character to queue.
REQ-007 SHALL have port fifo_en, input, 1, 1 = DEPTH-entry FIFO mode, 0 = single-entry holding-register mode.
REQ-008 SHALL have port fifo_clr, input, 1, single-cycle flush request.
REQ-009 SHALL have port tsr_load, input, 1, pop request from transmit FSM; head consumed this cycle.
REQ-010 SHALL have port not_op, input, 1, transmit FSM is in IDLE or START.
REQ-011 SHALL have port tsr_data, output, DATA_WIDTH, current head entry, combinational from storage.
REQ-012 SHALL have port thre, output, 1, holding register/FIFO empty.
REQ-013 SHALL have port temt, output, 1, thre & not_op.
REQ-014 SHALL have port full, output, 1, count equals active capacity.
REQ-015 SHALL have port count, output, log2(DEPTH)+1, number of valid entries.
REQ-016 SHALL have port ovr_err, output, 1, registered one-cycle pulse: write was dropped.
REQ-017 SHALL have port thre_int, output, 1, registered one-cycle pulse on a non-empty to empty transition.

Function
REQ-018 SHALL implement circular storage with log2(DEPTH)-bit write and read pointers that wrap DEPTH-1 -> 0, plus a separate count register.
REQ-019 SHALL set active capacity to DEPTH when fifo_en=1 and to 1 when fifo_en=0.
- Full condition: count == capacity.
REQ-020 SHALL accept a write when wr_en=1 and not full.
- Store at write pointer; increment write pointer and count at that edge.
- thre falls in the following cycle (1-cycle latency).
REQ-021 SHALL drop a write when wr_en=1 and full, leave all state unchanged, and pulse ovr_err the next cycle.
REQ-022 SHALL honour tsr_load only when count != 0.
- Increment read pointer and decrement count.
- tsr_load while empty is ignored, with no error.
REQ-023 SHALL accept a write and a pop in the same cycle with count unchanged.
- This includes the full case: the pop frees the slot, so the write is accepted and ovr_err stays 0.
REQ-024 SHALL apply fifo_clr with priority over same-cycle wr_en and tsr_load.
- Zero both pointers and count; storage contents unchanged.
REQ-025 SHALL perform an implicit flush, identical to fifo_clr, in the cycle after any fifo_en change.
- fifo_en is sampled into a register and the change is detected from that register.
REQ-026 SHALL drive thre = (count == 0) and full combinationally from the registered count.
REQ-027 SHALL pulse thre_int for one cycle after any edge where count goes from non-zero to 0, whether by pop or by flush.
- An already-empty flush SHALL NOT pulse thre_int.
REQ-028 SHALL present tsr_data = storage[read pointer] at all times; value is don't-care when thre=1.
REQ-029 SHALL keep count within 0..capacity; no wrap of count under any input combination.

Reset
REQ-030 SHALL, when presetn=0 at a rising pclk edge, clear pointers, count, ovr_err, thre_int and the sampled fifo_en register (to 0).
- Reset overrides all other inputs; storage is not reset.
REQ-031 SHALL after reset present thre=1, full=0, count=0, ovr_err=0, thre_int=0; temt follows not_op.
REQ-032 SHALL abandon any in-progress write or pop when reset asserts mid-operation; no partial state survives.

Verification
REQ-033 Bench SHALL cover holding mode: fifo_en=0, write 0xA5 -> next cycle thre=0, full=1, tsr_data=0xA5.
- Then write 0x3C -> ovr_err pulses 1 cycle, tsr_data stays 0xA5.
- Then tsr_load -> thre=1, thre_int pulses.
REQ-034 Bench SHALL cover FIFO mode fill: fifo_en=1, write 0x00..0x0F -> count=16, full=1.
- A 17th write -> ovr_err pulse.
- 16 pops -> tsr_data sequence 0x00..0x0F, then thre=1, one thre_int pulse.
REQ-035 Bench SHALL cover wrap: 10 writes, 10 pops, 10 writes -> pointers wrap past 15 and data order is preserved.
REQ-036 Bench SHALL cover simultaneous operations:
- Full FIFO with wr_en=1 and tsr_load=1 -> count stays 16, no ovr_err.
- Empty FIFO with both asserted -> count=1, tsr_data=wdata.
REQ-037 Bench SHALL cover flush: count=5 with fifo_clr=1, wr_en=1, tsr_load=1 -> count=0, thre_int pulses.
- Toggling fifo_en with count=3 -> count=0 one cycle later.
REQ-038 Bench SHALL cover reset: presetn=0 for one edge with count=7 and wr_en=1 -> count=0, thre=1, ovr_err=0, thre_int=0.
